lc3_mem_arbiter: RTL and testbench
==================================

// Module: lc3_mem_arbiter
// PURPOSE
//   Shares the single LC-3 memory port between two requesters: the CPU controller (MAR/MDR
//   path, fetch/load/store) and a debug/loader port used for program load and inspection.
//   Arbitrates fairly, sequences each access through a fixed-latency memory, and returns a
//   one-cycle ack per completed access. Sits between the controller's memory signals and
//   the memory macro.
// PARAMETERS
//   ADDR_W       16  address width
//   DATA_W       16  data width
//   MEM_LATENCY  2   cycles from mem_en (read) to valid mem_rdata; legal range >= 1
// PORTS
//   clk        in   1       clock
//   reset      in   1       synchronous, active-high
//   cpu_req    in   1       CPU access request; held until cpu_ack
//   cpu_we     in   1       1 = write, 0 = read
//   cpu_addr   in   ADDR_W  CPU address
//   cpu_wdata  in   DATA_W  CPU write data
//   cpu_rdata  out  DATA_W  CPU read data; valid with cpu_ack, held until next CPU read
//   cpu_ack    out  1       one-cycle completion pulse
//   dbg_req/dbg_we/dbg_addr/dbg_wdata/dbg_rdata/dbg_ack  same as cpu_*, for the debug port
//   mem_en     out  1       memory access strobe, one cycle per access
//   mem_we     out  1       memory write enable, qualified by mem_en
//   mem_addr   out  ADDR_W  latched address
//   mem_wdata  out  DATA_W  latched write data
//   mem_rdata  in   DATA_W  memory read data, valid MEM_LATENCY cycles after mem_en
//   grant      out  grant_t current owner (GRANT_NONE/GRANT_CPU/GRANT_DBG)
//   busy       out  1       state != IDLE
// BEHAVIOUR
//   - Reset: state IDLE; all outputs 0; grant = GRANT_NONE; last_owner = DBG, so CPU wins
//     the first tie. Reset mid-access aborts it: no ack, mem_en 0 next cycle. Held requests
//     are re-arbitrated from IDLE.
//   - FSM (arb_state_t):
//     IDLE:  no req -> IDLE. One req -> latch that port's we/addr/wdata, go to ISSUE.
//            Both -> grant the port != last_owner (alternate), go to ISSUE.
//     ISSUE: mem_en = 1, mem_we = latched we. Write -> RESP. Read -> WAIT, counter = MEM_LATENCY-1.
//     WAIT:  counter decrements. At counter == 0, capture mem_rdata into the owner's rdata reg
//            and go to RESP.
//     RESP:  owner's ack = 1 for exactly this cycle; last_owner <= owner; go to IDLE.
//   - Latency from the req-sampled cycle (cycle 0): write ack in cycle 2; read ack in cycle
//     MEM_LATENCY+2. Minimum of one IDLE cycle between accesses.
//   - Handshake: the requester keeps req and operands stable until it sees ack, then drops
//     req at that edge. Operands are latched in IDLE, so later changes do not affect an
//     access in flight. A req dropped before ack is a protocol violation: the access still
//     completes and acks.
//   - A non-owner's request during an access waits; it is never lost. Its ack and rdata
//     remain untouched. Write accesses never modify either rdata register.
//   - mem_addr/mem_wdata/mem_we are held from the latches while busy; all are 0 in IDLE.
//   - grant = owner during ISSUE/WAIT/RESP; GRANT_NONE in IDLE.
// STRUCTURE
//   - Package lc3 gets:
//     - arb_state_t {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP}
//     - grant_t {GRANT_NONE, GRANT_CPU, GRANT_DBG}
//     - LC3_MEM_LATENCY default constant
//   - Sub-module lc3_latency_counter: load/decrement/zero flag, width $clog2(MEM_LATENCY+1).
//   - FSM, arbitration and operand/rdata registers stay in this module.
// TESTING (MEM_LATENCY = 2 unless stated)
//   1. CPU read 0x3000 (mem holds 0x1234), req in cycle 0 -> mem_en only in cycle 1 with
//      addr 0x3000; cpu_ack only in cycle 4; cpu_rdata = 0x1234; dbg_ack stays 0.
//   2. dbg write 0x4000 <- 0xBEEF -> mem_en & mem_we in cycle 1, dbg_ack in cycle 2; a
//      following CPU read of 0x4000 returns 0xBEEF; dbg_rdata is unchanged.
//   3. After reset, cpu_req and dbg_req both held continuously with requesters re-raising
//      req after each ack -> grant sequence CPU, DBG, CPU, DBG; no port acked twice in a row.
//   4. dbg_req rises during a CPU read's WAIT -> CPU access completes and acks; dbg access
//      issues after the next IDLE; dbg_addr changed after latching has no effect.
//   5. Reset asserted in the WAIT cycle, cpu_req held -> next cycle IDLE, mem_en 0, no ack;
//      access re-issued and acked with correct data.
//   6. MEM_LATENCY = 1 build: CPU read acked in cycle 3, write in cycle 2; busy high exactly
//      from cycle 1 until the ack cycle.

Source files
------------

// File: rtl/lc3_pkg.sv
// lc3_pkg: shared types and defaults for the LC-3
// memory arbiter slice.
package lc3_pkg;

  localparam int LC3_MEM_LATENCY = 2;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_t;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_CPU,
    GRANT_DBG
  } grant_t;

  // On a tie the port that did not own the last access wins.
  function automatic grant_t pick_owner(
    input logic   cpu,
    input logic   dbg,
    input grant_t last
  );
    grant_t g;
    g = GRANT_NONE;
    unique case (1'b1)
      (cpu && dbg):
        g = (last == GRANT_CPU) ? GRANT_DBG
                                : GRANT_CPU;
      (cpu && !dbg): g = GRANT_CPU;
      (!cpu && dbg): g = GRANT_DBG;
      default:       g = GRANT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/lc3_latency_counter.sv
// lc3_latency_counter: loadable down-counter that
// times the memory read latency.
module lc3_latency_counter #(
  parameter int MAX = 2,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load wins over decrement; saturate at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter: shares the LC-3 memory port between
// the CPU controller and the debug/loader port.
module lc3_mem_arbiter
  import lc3_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int MEM_LATENCY = LC3_MEM_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output grant_t            grant,
  output logic              busy
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(MEM_LATENCY - 1);

  arb_state_t        state_q, state_d;
  grant_t            owner_q, owner_d;
  grant_t            last_q, last_d;
  grant_t            pick;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rd_q, cpu_rd_d;
  logic [DATA_W-1:0] dbg_rd_q, dbg_rd_d;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_zero;

  lc3_latency_counter #(
    .MAX (MEM_LATENCY),
    .W   (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (CNT_LOAD),
    .zero_o     (cnt_zero)
  );

  // Arbitration, operand latching and access sequencing.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cpu_rd_d = cpu_rd_q;
    dbg_rd_d = dbg_rd_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    pick     = pick_owner(cpu_req, dbg_req, last_q);
    unique case (state_q)
      ARB_IDLE: begin
        if (pick == GRANT_CPU) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
        end else if (pick == GRANT_DBG) begin
          we_d    = dbg_we;
          addr_d  = dbg_addr;
          wdata_d = dbg_wdata;
        end
        if (pick != GRANT_NONE) begin
          owner_d = pick;
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (we_q) begin
          state_d = ARB_RESP;
        end else begin
          cnt_load = 1'b1;
          state_d  = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (cnt_zero) begin
          if (owner_q == GRANT_CPU) begin
            cpu_rd_d = mem_rdata;
          end else begin
            dbg_rd_d = mem_rdata;
          end
          state_d = ARB_RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ARB_RESP: begin
        last_d  = owner_q;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State, owner history and operand/rdata registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      owner_q  <= GRANT_NONE;
      last_q   <= GRANT_DBG;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cpu_rd_q <= '0;
      dbg_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cpu_rd_q <= cpu_rd_d;
      dbg_rd_q <= dbg_rd_d;
    end
  end

  assign busy      = (state_q != ARB_IDLE);
  assign grant     = busy ? owner_q : GRANT_NONE;
  assign mem_en    = (state_q == ARB_ISSUE);
  assign mem_we    = busy & we_q;
  assign mem_addr  = busy ? addr_q : '0;
  assign mem_wdata = busy ? wdata_q : '0;
  assign cpu_ack   = (state_q == ARB_RESP) &&
                     (owner_q == GRANT_CPU);
  assign dbg_ack   = (state_q == ARB_RESP) &&
                     (owner_q == GRANT_DBG);
  assign cpu_rdata = cpu_rd_q;
  assign dbg_rdata = dbg_rd_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// tb_lc3_mem_arbiter: directed and randomized checks
// of the LC-3 memory arbiter.
module tb_lc3_mem_arbiter;
  import lc3_pkg::*;

  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dbg_req, dbg_we, dbg_ack;
  logic [15:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        mem_en, mem_we, busy;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  grant_t      grant;

  logic        c1_req, c1_we, c1_ack, d1_ack;
  logic [15:0] c1_addr, c1_wdata, c1_rdata, d1_rdata;
  logic        m1_en, m1_we, b1;
  logic [15:0] m1_addr, m1_wdata, m1_rdata;
  grant_t      g1;

  int n_chk = 0;
  int n_fail = 0;

  lc3_mem_arbiter #(.MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .grant(grant), .busy(busy)
  );

  lc3_mem_arbiter #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .cpu_req(c1_req), .cpu_we(c1_we),
    .cpu_addr(c1_addr), .cpu_wdata(c1_wdata),
    .cpu_rdata(c1_rdata), .cpu_ack(c1_ack),
    .dbg_req(1'b0), .dbg_we(1'b0),
    .dbg_addr(16'h0000), .dbg_wdata(16'h0000),
    .dbg_rdata(d1_rdata), .dbg_ack(d1_ack),
    .mem_en(m1_en), .mem_we(m1_we),
    .mem_addr(m1_addr), .mem_wdata(m1_wdata),
    .mem_rdata(m1_rdata),
    .grant(g1), .busy(b1)
  );

  function automatic logic [15:0] init_val(
    input logic [15:0] a);
    return (a == 16'h3000) ? 16'h1234
                           : (a ^ 16'h5A5A);
  endfunction

  // Memory behind the LAT=2 instance.
  logic [15:0] mem_q [0:65535];
  bit          wr_q  [0:65535];
  logic [15:0] pipe_q [0:LAT-1];

  function automatic logic [15:0] mem_rd(
    input logic [15:0] a);
    return wr_q[a] ? mem_q[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
      wr_q[mem_addr]  <= 1'b1;
    end
    pipe_q[0] <= (mem_en && !mem_we)
               ? mem_rd(mem_addr)
               : 16'($urandom);
    for (int i = 1; i < LAT; i++)
      pipe_q[i] <= pipe_q[i-1];
  end
  assign mem_rdata = pipe_q[LAT-1];

  // Read-only memory behind the LAT=1 instance.
  always @(posedge clk) begin
    m1_rdata <= (m1_en && !m1_we)
              ? init_val(m1_addr)
              : 16'($urandom);
  end

  // Reference contents as seen by the requesters.
  logic [15:0] sh_mem [0:65535];
  bit          sh_wr  [0:65535];

  function automatic logic [15:0] ref_rd(
    input logic [15:0] a);
    return sh_wr[a] ? sh_mem[a] : init_val(a);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    c1_req  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One isolated access; called at the negedge of cycle 0.
  task automatic access(input bit dbg,
                        input bit we,
                        input logic [15:0] a,
                        input logic [15:0] wd,
                        input string tag);
    int          ack_at;
    logic [15:0] keep_self, keep_oth, exp_rd;
    ack_at    = we ? 2 : LAT + 2;
    keep_self = dbg ? dbg_rdata : cpu_rdata;
    keep_oth  = dbg ? cpu_rdata : dbg_rdata;
    exp_rd    = we ? keep_self : ref_rd(a);
    if (dbg) begin
      dbg_req = 1'b1; dbg_we = we;
      dbg_addr = a; dbg_wdata = wd;
    end else begin
      cpu_req = 1'b1; cpu_we = we;
      cpu_addr = a; cpu_wdata = wd;
    end
    for (int k = 1; k <= ack_at + 1; k++) begin
      @(negedge clk);
      chk({tag, ".en"}, mem_en, k == 1);
      if (k == 1) begin
        chk({tag, ".addr"}, mem_addr, a);
        chk({tag, ".we"}, mem_we, we);
        if (we) chk({tag, ".wd"}, mem_wdata, wd);
      end
      chk({tag, ".ack"},
          dbg ? dbg_ack : cpu_ack, k == ack_at);
      chk({tag, ".oack"},
          dbg ? cpu_ack : dbg_ack, 1'b0);
      chk({tag, ".busy"}, busy, k <= ack_at);
      chk({tag, ".grant"}, grant,
          (k > ack_at) ? GRANT_NONE
          : (dbg ? GRANT_DBG : GRANT_CPU));
      if (k == ack_at) begin
        chk({tag, ".rd"},
            dbg ? dbg_rdata : cpu_rdata, exp_rd);
        if (dbg) dbg_req = 1'b0;
        else     cpu_req = 1'b0;
        if (we) begin
          sh_mem[a] = wd;
          sh_wr[a]  = 1'b1;
        end
      end
    end
    chk({tag, ".ord"},
        dbg ? cpu_rdata : dbg_rdata, keep_oth);
  endtask

  // Randomized requester for one port.
  task automatic requester(input bit dbg,
                           input int n);
    logic [15:0] a, wd;
    bit          we, got;
    string       tg;
    for (int i = 0; i < n; i++) begin
      a  = 16'h1000 + 16'($urandom_range(0, 7));
      wd = 16'($urandom);
      we = 1'($urandom_range(0, 1));
      tg = $sformatf("rnd.%s%0d",
                     dbg ? "dbg" : "cpu", i);
      repeat (1 + $urandom_range(0, 3))
        @(negedge clk);
      if (dbg) begin
        dbg_req = 1'b1; dbg_we = we;
        dbg_addr = a; dbg_wdata = wd;
      end else begin
        cpu_req = 1'b1; cpu_we = we;
        cpu_addr = a; cpu_wdata = wd;
      end
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
        @(negedge clk);
        got = dbg ? dbg_ack : cpu_ack;
      end
      chk({tg, ".acked"}, got, 1'b1);
      if (got) begin
        if (we) begin
          sh_mem[a] = wd;
          sh_wr[a]  = 1'b1;
        end else begin
          chk({tg, ".rd"},
              dbg ? dbg_rdata : cpu_rdata,
              ref_rd(a));
        end
      end
      if (dbg) dbg_req = 1'b0;
      else     cpu_req = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nack;
    bit          cre, dre;
    logic [15:0] exp_rd;
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0;
    cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0;
    dbg_addr = 0; dbg_wdata = 0;
    c1_req = 0; c1_we = 0;
    c1_addr = 0; c1_wdata = 0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst.busy", busy, 1'b0);
    chk("rst.grant", grant, GRANT_NONE);
    chk("rst.en", mem_en, 1'b0);
    chk("rst.we", mem_we, 1'b0);
    chk("rst.addr", mem_addr, 16'h0);
    chk("rst.wd", mem_wdata, 16'h0);
    chk("rst.cack", cpu_ack, 1'b0);
    chk("rst.dack", dbg_ack, 1'b0);
    chk("rst.crd", cpu_rdata, 16'h0);
    chk("rst.drd", dbg_rdata, 16'h0);
    chk("rst.b1", b1, 1'b0);
    chk("rst.c1rd", c1_rdata, 16'h0);
    reset = 1'b0;
    @(negedge clk);

    // 1: CPU read
    access(1'b0, 1'b0, 16'h3000, 16'h0, "t1");
    chk("t1.data", cpu_rdata, 16'h1234);

    // 2: debug write, then CPU readback
    access(1'b1, 1'b1, 16'h4000, 16'hBEEF, "t2w");
    access(1'b0, 1'b0, 16'h4000, 16'h0, "t2r");
    chk("t2.data", cpu_rdata, 16'hBEEF);

    // 3: both ports contend continuously
    do_reset();
    cpu_we = 0; dbg_we = 0;
    cpu_addr = 16'h0100; dbg_addr = 16'h0200;
    cpu_req = 1; dbg_req = 1;
    nack = 0; cre = 0; dre = 0;
    for (int k = 0; k < 80 && nack < 4; k++) begin
      @(negedge clk);
      if (cre) begin cpu_req = 1; cre = 0; end
      if (dre) begin dbg_req = 1; dre = 0; end
      if (cpu_ack || dbg_ack) begin
        chk($sformatf("t3.both%0d", nack),
            cpu_ack && dbg_ack, 1'b0);
        chk($sformatf("t3.who%0d", nack),
            cpu_ack ? GRANT_CPU : GRANT_DBG,
            (nack % 2 == 0) ? GRANT_CPU
                            : GRANT_DBG);
        if (cpu_ack) begin
          chk($sformatf("t3.crd%0d", nack),
              cpu_rdata, ref_rd(16'h0100));
          cpu_req = 0; cre = 1;
        end else begin
          chk($sformatf("t3.drd%0d", nack),
              dbg_rdata, ref_rd(16'h0200));
          dbg_req = 0; dre = 1;
        end
        nack++;
      end
    end
    chk("t3.count", nack, 4);
    cpu_req = 0; dbg_req = 0;
    repeat (2) @(negedge clk);

    // 4: debug request arrives during CPU read
    cpu_we = 0; cpu_addr = 16'h0500;
    cpu_req = 1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk($sformatf("t4.en%0d", k), mem_en,
          (k == 1) || (k == 6));
      chk($sformatf("t4.cack%0d", k), cpu_ack,
          k == 4);
      chk($sformatf("t4.dack%0d", k), dbg_ack,
          k == 9);
      if (k == 5) chk("t4.idle", busy, 1'b0);
      if (k == 1) chk("t4.a1", mem_addr, 16'h0500);
      if (k == 6 || k == 7)
        chk($sformatf("t4.a%0d", k),
            mem_addr, 16'h0600);
      if (k == 4)
        chk("t4.crd", cpu_rdata, ref_rd(16'h0500));
      if (k == 9)
        chk("t4.drd", dbg_rdata, ref_rd(16'h0600));
      if (k == 2) begin
        dbg_we = 0; dbg_addr = 16'h0600;
        dbg_req = 1;
      end
      if (k == 4) cpu_req = 0;
      if (k == 6) dbg_addr = 16'h0700;
      if (k == 9) dbg_req = 0;
    end

    // 5: reset in the WAIT cycle, CPU req held
    exp_rd = ref_rd(16'h0800);
    cpu_we = 0; cpu_addr = 16'h0800;
    cpu_req = 1;
    @(negedge clk);
    chk("t5.en1", mem_en, 1'b1);
    @(negedge clk);
    chk("t5.busy2", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("t5.en3", mem_en, 1'b0);
    chk("t5.busy3", busy, 1'b0);
    chk("t5.ack3", cpu_ack, 1'b0);
    chk("t5.grant3", grant, GRANT_NONE);
    chk("t5.crd3", cpu_rdata, 16'h0);
    chk("t5.drd3", dbg_rdata, 16'h0);
    reset = 1'b0;
    for (int k = 4; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("t5.en%0d", k), mem_en,
          k == 4);
      chk($sformatf("t5.ack%0d", k), cpu_ack,
          k == 7);
      if (k == 7) begin
        chk("t5.rd", cpu_rdata, exp_rd);
        cpu_req = 0;
      end
    end

    // 6: MEM_LATENCY = 1 instance
    c1_we = 0; c1_addr = 16'h0900; c1_req = 1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("t6r.en%0d", k), m1_en,
          k == 1);
      chk($sformatf("t6r.ack%0d", k), c1_ack,
          k == 3);
      chk($sformatf("t6r.busy%0d", k), b1,
          k <= 3);
      if (k == 3) begin
        chk("t6r.rd", c1_rdata, init_val(16'h0900));
        c1_req = 0;
      end
    end
    c1_we = 1; c1_addr = 16'h0A00;
    c1_wdata = 16'h5555; c1_req = 1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("t6w.en%0d", k), m1_en,
          k == 1);
      if (k == 1) chk("t6w.we", m1_we, 1'b1);
      chk($sformatf("t6w.ack%0d", k), c1_ack,
          k == 2);
      chk($sformatf("t6w.busy%0d", k), b1,
          k <= 2);
      if (k == 2) begin
        chk("t6w.rd", c1_rdata, init_val(16'h0900));
        c1_req = 0;
      end
    end

    // Randomized traffic on both ports
    @(negedge clk);
    fork
      requester(1'b0, 25);
      requester(1'b1, 25);
    join
    repeat (3) @(negedge clk);
    chk("end.idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
